// File: rtl/fifo_read_drain.sv
// Reader-side drain engine: pulls words out of the synchronous FIFO using a credit scheme and re-presents them as a valid/ready stream.
// Optional flush port is enabled by defining FIFO_RD_FLUSH_EN.
module fifo_read_drain #(
   parameter int WIDTH     = 8,
   parameter int RD_LAT    = 1,
   parameter int BUF_DEPTH = 3
) (
   input  logic             clock,
   input  logic             rst,
`ifdef FIFO_RD_FLUSH_EN
   input  logic             flush,
`endif
   output logic             fifo_rd,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             idle
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OW = $clog2(BUF_DEPTH + 1);
   localparam int IW = $clog2(RD_LAT + 1);
   localparam int SW = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [IW-1:0]    inflight;
   logic             push, pop, flush_i;
   logic [WIDTH-1:0] mem_q [BUF_DEPTH];

`ifdef FIFO_RD_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credits count both buffered words and reads still travelling through the FIFO latency.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + IW'(pipe_q[i]);
      end
      push    = pipe_q[RD_LAT-1];
      m_valid = (occ_q != '0);
      pop     = m_valid && m_ready;
      m_data  = m_valid ? mem_q[head_q] : '0;
      idle    = (occ_q == '0) && (inflight == '0) && fifo_empty;
      fifo_rd = rst && !fifo_empty && !flush_i &&
                ((SW'(occ_q) + SW'(inflight)) < SW'(BUF_DEPTH));

      pipe_d    = '0;
      pipe_d[0] = fifo_rd;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
         pipe_d = '0;
      end else begin
         if (push) tail_d = wrap_inc(tail_q);
         if (pop)  head_d = wrap_inc(head_q);
         if (push && !pop)      occ_d = occ_q + 1'b1;
         else if (!push && pop) occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         pipe_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         pipe_q <= pipe_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush_i) mem_q[tail_q] <= fifo_data;
   end

   // The credit rule makes overflow impossible; this catches a broken credit computation.
   assert property (@(posedge clock) disable iff (!rst)
      !(push && !pop && !flush_i && (occ_q == OW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_read_drain.sv
// Scoreboard bench for fifo_read_drain: a behavioural FIFO feeds the DUT, a monitor checks the output stream.
module tb_fifo_read_drain;

   localparam int WIDTH     = 8;
   localparam int RD_LAT    = 1;
   localparam int BUF_DEPTH = 3;

   logic             clock = 1'b0;
   logic             rst = 1'b0;
   logic             fifo_rd;
   logic             fifo_empty = 1'b1;
   logic [WIDTH-1:0] fifo_data = '0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic             idle;
`ifdef FIFO_RD_FLUSH_EN
   logic             flush = 1'b0;
`endif

   logic [WIDTH-1:0] wr_q[$];
   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int rd_count = 0;
   int acc_count = 0;
   int credit_base = 0;
   bit stall_check_en = 1'b1;
   logic prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   fifo_read_drain #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clock      (clock),
      .rst        (rst),
`ifdef FIFO_RD_FLUSH_EN
      .flush      (flush),
`endif
      .fifo_rd    (fifo_rd),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .idle       (idle)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] word);
      wr_q.push_back(word);
      exp_q.push_back(word);
   endtask

   task automatic waitDrain(input int max_cycles);
      int c = 0;
      while (exp_q.size() != 0 && c < max_cycles) begin
         @(posedge clock);
         c++;
      end
      #1;
      checkOutput("drain_done", exp_q.size(), 0);
      repeat (2) @(posedge clock);
      #1;
   endtask

   // Synchronous FIFO with registered data_out: one edge of read latency, writes land at the edge.
   always @(posedge clock) begin
      if (fifo_rd && fq.size() != 0) begin
         fifo_data <= fq.pop_front();
         rd_count  <= rd_count + 1;
      end
      while (wr_q.size() != 0) fq.push_back(wr_q.pop_front());
      fifo_empty <= (fq.size() == 0);
   end

   // Monitor samples on the falling edge, i.e. the values the next rising edge will act on.
   always @(negedge clock) begin
      if (rst) begin
         checkOutput("rd_while_empty", {31'd0, fifo_rd && fifo_empty}, 0);
         checkOutput("outstanding_over_depth",
                     {31'd0, (rd_count - acc_count - credit_base) > BUF_DEPTH}, 0);
         if (stall_check_en && prev_stall) begin
            checkOutput("stall_valid", {31'd0, m_valid}, 1);
            checkOutput("stall_data", {24'd0, m_data}, {24'd0, prev_data});
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("[TB] FAIL sb_unexpected: got word %0d, expected none", m_data);
            end else begin
               checkOutput("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
            acc_count++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int run;
      int wait_c;

      // Reset with a pre-filled FIFO
      applyStimulus(8'd2);
      applyStimulus(8'd3);
      applyStimulus(8'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         checkOutput("reset_m_valid", {31'd0, m_valid}, 0);
         checkOutput("reset_fifo_rd", {31'd0, fifo_rd}, 0);
      end
      checkOutput("reset_m_data", {24'd0, m_data}, 0);
      checkOutput("reset_idle", {31'd0, idle}, 0);
      credit_base = rd_count - acc_count;
      rst = 1'b1;
      m_ready = 1'b1;
      waitDrain(50);
      checkOutput("idle_after_drain", {31'd0, idle}, 1);

      // Streaming: 20 words back to back
      for (int i = 0; i < 20; i++) applyStimulus(WIDTH'(i));
      @(posedge clock); #1;
      checkOutput("latency_edge1", {31'd0, m_valid}, 0);
      @(posedge clock); #1;
      checkOutput("latency_edge2", {31'd0, m_valid}, 0);
      @(posedge clock); #1;
      checkOutput("latency_edge3", {31'd0, m_valid}, 1);
      run = 0;
      while (m_valid && run < 30) begin
         run++;
         @(posedge clock);
         #1;
      end
      checkOutput("stream_run_length", run, 20);
      waitDrain(50);

      // Backpressure with m_ready pattern 1,0,0
      for (int i = 20; i < 30; i++) applyStimulus(WIDTH'(i));
      for (int c = 0; c < 60; c++) begin
         m_ready = (c % 3 == 0);
         @(posedge clock);
         #1;
      end
      m_ready = 1'b1;
      waitDrain(100);

      // FIFO runs empty mid-stream
      applyStimulus(8'd30);
      applyStimulus(8'd31);
      waitDrain(50);
      repeat (3) @(posedge clock);
      #1;
      applyStimulus(8'd32);
      waitDrain(50);

      // Asynchronous reset with two words buffered and one in flight
      stall_check_en = 1'b0;
      m_ready = 1'b0;
      for (int i = 50; i < 55; i++) applyStimulus(WIDTH'(i));
      repeat (4) @(posedge clock);
      #1;
      checkOutput("pre_reset_valid", {31'd0, m_valid}, 1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("async_reset_m_valid", {31'd0, m_valid}, 0);
      checkOutput("async_reset_fifo_rd", {31'd0, fifo_rd}, 0);
      checkOutput("async_reset_m_data", {24'd0, m_data}, 0);
      exp_q.delete();
      exp_q.push_back(8'd53);
      exp_q.push_back(8'd54);
      repeat (2) @(posedge clock);
      #1;
      credit_base = rd_count - acc_count;
      rst = 1'b1;
      m_ready = 1'b1;
      @(posedge clock);
      #1;
      stall_check_en = 1'b1;
      waitDrain(50);

`ifdef FIFO_RD_FLUSH_EN
      // Flush with two words buffered and one in flight
      stall_check_en = 1'b0;
      m_ready = 1'b0;
      for (int i = 60; i < 65; i++) applyStimulus(WIDTH'(i));
      repeat (4) @(posedge clock);
      #1;
      checkOutput("pre_flush_valid", {31'd0, m_valid}, 1);
      flush = 1'b1;
      #1;
      checkOutput("flush_fifo_rd", {31'd0, fifo_rd}, 0);
      @(posedge clock);
      #1;
      flush = 1'b0;
      checkOutput("flush_m_valid", {31'd0, m_valid}, 0);
      credit_base = rd_count - acc_count;
      exp_q.delete();
      exp_q.push_back(8'd63);
      exp_q.push_back(8'd64);
      m_ready = 1'b1;
      @(posedge clock);
      #1;
      stall_check_en = 1'b1;
      waitDrain(50);
`endif

      wait_c = 0;
      while (!idle && wait_c < 20) begin
         @(posedge clock);
         #1;
         wait_c++;
      end
      checkOutput("final_idle", {31'd0, idle}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
